// File: rtl/pfifo_gearbox.sv
// Unit-granular gearbox FIFO: variable-width joins and pops in strict unit order,
// circular unit store, registered pop stage, flush, drain of a short tail and live level.
module pfifo_gearbox #(
  parameter int UNIT_W = 8,
  parameter int LANES  = 32,
  parameter int DEPTH  = 96,
  localparam int AW = $clog2(LANES),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rst,
  input  logic                      i_flush,
  input  logic                      i_join_en,
  input  logic [AW-1:0]             i_join_amount,
  input  logic [LANES*UNIT_W-1:0]   i_join_data,
  output logic                      o_join_permit,
  input  logic                      i_pop_permit,
  input  logic [AW-1:0]             i_pop_amount,
  input  logic                      i_pop_drain,
  output logic                      o_pop_en,
  output logic                      o_pop_valid,
  output logic [LANES*UNIT_W-1:0]   o_pop_data,
  output logic [AW-1:0]             o_pop_count,
  output logic [CW-1:0]             o_level
);

  // One extra bit so level + amount never wraps in comparisons.
  localparam int XW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);

  logic [UNIT_W-1:0]       mem [DEPTH];
  logic [PW-1:0]           rdPtrReg, wrPtrReg;
  logic [CW-1:0]           levelReg;
  logic                    popValidReg;
  logic [LANES*UNIT_W-1:0] popDataReg, popDataNext;
  logic [AW-1:0]           popCountReg;

  logic [XW-1:0] levelX, nJoin, nPopReq, nPop, levelNext;
  logic          joinFire, normalOk, drainOk;
  logic [PW-1:0] wrIdx [LANES];
  logic [PW-1:0] rdIdx [LANES];

  // Pointer + offset never exceeds 2*DEPTH-1, so one conditional subtract wraps it.
  function automatic logic [PW-1:0] wrapIdx(input logic [XW-1:0] sum);
    if (sum >= DEPTH_X) return PW'(sum - DEPTH_X);
    return PW'(sum);
  endfunction

  assign levelX  = XW'(levelReg);
  assign nJoin   = XW'(i_join_amount) + XW'(1);
  assign nPopReq = XW'(i_pop_amount) + XW'(1);

  assign o_join_permit = !i_rx_rst && !i_flush && ((levelX + nJoin) <= DEPTH_X);
  assign joinFire      = i_join_en && o_join_permit;

  // Pop decision looks only at the stored level; a same-cycle join is invisible.
  assign normalOk = (levelX >= nPopReq);
  assign drainOk  = i_pop_drain && (levelX != '0) && (levelX < nPopReq);
  assign o_pop_en = !i_rx_rst && !i_flush && i_pop_permit && (normalOk || drainOk);
  assign nPop     = normalOk ? nPopReq : levelX;

  assign levelNext = levelX + (joinFire ? nJoin : '0) - (o_pop_en ? nPop : '0);

  for (genvar gi = 0; gi < LANES; gi++) begin : gLane
    assign wrIdx[gi] = wrapIdx(XW'(wrPtrReg) + XW'(gi));
    assign rdIdx[gi] = wrapIdx(XW'(rdPtrReg) + XW'(gi));
    assign popDataNext[gi*UNIT_W +: UNIT_W] = (XW'(gi) < nPop) ? mem[rdIdx[gi]] : '0;
  end

  // Joined units land after the stored ones; permit guarantees no overlap with a pop.
  always_ff @(posedge i_core_clk) begin
    if (joinFire) begin
      for (int k = 0; k < LANES; k++) begin
        if (XW'(k) < nJoin) mem[wrIdx[k]] <= i_join_data[k*UNIT_W +: UNIT_W];
      end
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      levelReg    <= '0;
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      popValidReg <= 1'b0;
      popDataReg  <= '0;
      popCountReg <= '0;
    end else if (i_flush) begin
      levelReg    <= '0;
      rdPtrReg    <= '0;
      wrPtrReg    <= '0;
      popValidReg <= 1'b0;
    end else begin
      levelReg    <= CW'(levelNext);
      popValidReg <= o_pop_en;
      if (joinFire) wrPtrReg <= wrapIdx(XW'(wrPtrReg) + nJoin);
      if (o_pop_en) begin
        rdPtrReg    <= wrapIdx(XW'(rdPtrReg) + nPop);
        popDataReg  <= popDataNext;
        popCountReg <= AW'(nPop - XW'(1));
      end
    end
  end

  assign o_pop_valid = popValidReg;
  assign o_pop_data  = popDataReg;
  assign o_pop_count = popCountReg;
  assign o_level     = levelReg;

endmodule

// File: tb/tb_pfifo_gearbox.sv
// Bench for pfifo_gearbox: directed vector table, random run against a unit-queue
// model, and a narrow re-parametrised instance.
module tb_pfifo_gearbox;

  localparam int UW = 8, LN = 32, DP = 96, AW = 5, CW = 7, DW = LN * UW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, joinEn, joinPermit, popPermit, drain, popEn, popValid;
  logic [AW-1:0] joinAmt, popAmt, popCount;
  logic [DW-1:0] joinData, popData;
  logic [CW-1:0] level;

  logic        bRst, bFlush, bJoinEn, bJoinPermit, bPopPermit, bDrain, bPopEn, bPopValid;
  logic [2:0]  bJoinAmt, bPopAmt, bPopCount;
  logic [31:0] bJoinData, bPopData;
  logic [4:0]  bLevel;

  pfifo_gearbox #(.UNIT_W(UW), .LANES(LN), .DEPTH(DP)) dutA (
    .i_core_clk(clk), .i_rx_rst(rst), .i_flush(flush),
    .i_join_en(joinEn), .i_join_amount(joinAmt), .i_join_data(joinData),
    .o_join_permit(joinPermit), .i_pop_permit(popPermit), .i_pop_amount(popAmt),
    .i_pop_drain(drain), .o_pop_en(popEn), .o_pop_valid(popValid),
    .o_pop_data(popData), .o_pop_count(popCount), .o_level(level)
  );

  pfifo_gearbox #(.UNIT_W(4), .LANES(8), .DEPTH(20)) dutB (
    .i_core_clk(clk), .i_rx_rst(bRst), .i_flush(bFlush),
    .i_join_en(bJoinEn), .i_join_amount(bJoinAmt), .i_join_data(bJoinData),
    .o_join_permit(bJoinPermit), .i_pop_permit(bPopPermit), .i_pop_amount(bPopAmt),
    .i_pop_drain(bDrain), .o_pop_en(bPopEn), .o_pop_valid(bPopValid),
    .o_pop_data(bPopData), .o_pop_count(bPopCount), .o_level(bLevel)
  );

  int passCnt = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic setJoinData(input logic [7:0] base, input int n);
    for (int k = 0; k < LN; k++)
      joinData[k*8 +: 8] = (k < n) ? base + 8'(k) : 8'($urandom);
  endtask

  typedef struct {
    logic rst, flush, jEn; int jAmt; logic [7:0] jBase;
    logic pPerm; int pAmt; logic drain;
    logic ePermit, ePopEn; int eLevel; logic eValid; int eCount;
    int dMode; logic [63:0] eData;
  } vec_t;

  vec_t tbl [19];

  logic [7:0]    q[$];
  logic [DW-1:0] mData;
  logic          mValid;
  int            mCount;

  initial begin
    rst = 1'b1; flush = 1'b0; joinEn = 1'b0; joinAmt = '0; joinData = '0;
    popPermit = 1'b0; popAmt = '0; drain = 1'b0;
    bRst = 1'b1; bFlush = 1'b0; bJoinEn = 1'b0; bJoinAmt = '0; bJoinData = '0;
    bPopPermit = 1'b0; bPopAmt = '0; bDrain = 1'b0;

    // dMode: 0 skip data, 1 full data equals zero-extended eData, 2 low 64 bits only
    tbl[0]  = '{1,0,0, 0,8'h00, 0, 0,0, 0,0,  0,0, 0,1,64'h0};
    tbl[1]  = '{0,0,1, 4,8'h01, 0, 0,0, 1,0,  5,0, 0,1,64'h0};
    tbl[2]  = '{0,0,0, 0,8'h00, 1, 2,0, 1,1,  2,1, 2,1,64'h030201};
    tbl[3]  = '{0,0,0, 0,8'h00, 0, 0,0, 1,0,  2,0, 2,1,64'h030201};
    tbl[4]  = '{0,0,0, 0,8'h00, 1, 1,0, 1,1,  0,1, 1,1,64'h0504};
    tbl[5]  = '{0,0,1,31,8'h10, 0, 0,0, 1,0, 32,0, 1,1,64'h0504};
    tbl[6]  = '{0,0,1,31,8'h30, 0, 0,0, 1,0, 64,0, 1,0,64'h0};
    tbl[7]  = '{0,0,1,31,8'h50, 0, 0,0, 1,0, 96,0, 1,0,64'h0};
    tbl[8]  = '{0,0,1, 0,8'h00, 0, 0,0, 0,0, 96,0, 1,0,64'h0};
    tbl[9]  = '{0,0,0, 0,8'h00, 1,31,0, 0,1, 64,1,31,2,64'h1716151413121110};
    tbl[10] = '{0,0,1,31,8'h70, 1,31,0, 1,1, 64,1,31,2,64'h3736353433323130};
    tbl[11] = '{0,0,0, 0,8'h00, 1,23,0, 1,1, 40,1,23,2,64'h5756555453525150};
    tbl[12] = '{0,1,1,31,8'hE0, 1, 0,0, 0,0,  0,0,23,2,64'h5756555453525150};
    tbl[13] = '{0,0,1, 2,8'hA0, 0, 0,0, 1,0,  3,0,23,0,64'h0};
    tbl[14] = '{0,0,0, 0,8'h00, 1, 7,0, 1,0,  3,0,23,0,64'h0};
    tbl[15] = '{0,0,0, 0,8'h00, 1, 7,1, 1,1,  0,1, 2,1,64'hA2A1A0};
    tbl[16] = '{0,0,0, 0,8'h00, 1, 0,1, 1,0,  0,0, 2,1,64'hA2A1A0};
    tbl[17] = '{0,0,1, 4,8'hC0, 1, 0,0, 1,0,  5,0, 2,0,64'h0};
    tbl[18] = '{1,0,1, 0,8'h00, 1, 0,0, 0,0,  0,0, 0,1,64'h0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; flush = tbl[i].flush; joinEn = tbl[i].jEn;
      joinAmt = AW'(tbl[i].jAmt); setJoinData(tbl[i].jBase, tbl[i].jAmt + 1);
      popPermit = tbl[i].pPerm; popAmt = AW'(tbl[i].pAmt); drain = tbl[i].drain;
      #1;
      check($sformatf("row%0d_permit", i), DW'(joinPermit), DW'(tbl[i].ePermit));
      check($sformatf("row%0d_popen", i), DW'(popEn), DW'(tbl[i].ePopEn));
      @(posedge clk); #1;
      check($sformatf("row%0d_level", i), DW'(level), DW'(tbl[i].eLevel));
      check($sformatf("row%0d_valid", i), DW'(popValid), DW'(tbl[i].eValid));
      check($sformatf("row%0d_count", i), DW'(popCount), DW'(tbl[i].eCount));
      if (tbl[i].dMode == 1) check($sformatf("row%0d_data", i), popData, DW'(tbl[i].eData));
      if (tbl[i].dMode == 2) check($sformatf("row%0d_datalo", i), DW'(popData[63:0]), DW'(tbl[i].eData));
    end

    // Random phase; DUT is in reset state after the last table row.
    q.delete(); mData = '0; mValid = 1'b0; mCount = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int nj, npr, np, nq;
      logic ePermit, eGrant;
      @(negedge clk);
      rst   = ($urandom_range(0, 999) == 0);
      flush = ($urandom_range(0, 199) == 0);
      joinEn = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      joinAmt = ($urandom_range(0, 3) == 0) ? AW'(31) : AW'($urandom_range(0, 31));
      for (int k = 0; k < LN; k++) joinData[k*8 +: 8] = 8'($urandom);
      popPermit = ($urandom_range(0, 3) != 0);
      popAmt = ($urandom_range(0, 3) == 0) ? AW'(31) : AW'($urandom_range(0, 31));
      drain = ($urandom_range(0, 2) == 0);
      nj = int'(joinAmt) + 1;
      npr = int'(popAmt) + 1;
      nq = q.size();
      ePermit = !rst && !flush && (nq + nj <= DP);
      eGrant = 1'b0; np = 0;
      if (!rst && !flush && popPermit) begin
        if (nq >= npr) begin eGrant = 1'b1; np = npr; end
        else if (drain && nq > 0) begin eGrant = 1'b1; np = nq; end
      end
      #1;
      check($sformatf("rand%0d_permit", cyc), DW'(joinPermit), DW'(ePermit));
      check($sformatf("rand%0d_popen", cyc), DW'(popEn), DW'(eGrant));
      if (rst) begin
        q.delete(); mValid = 1'b0; mData = '0; mCount = 0;
      end else if (flush) begin
        q.delete(); mValid = 1'b0;
      end else begin
        mValid = eGrant;
        if (eGrant) begin
          mData = '0;
          for (int k = 0; k < np; k++) mData[k*8 +: 8] = q.pop_front();
          mCount = np - 1;
        end
        if (joinEn && ePermit)
          for (int k = 0; k < nj; k++) q.push_back(joinData[k*8 +: 8]);
      end
      @(posedge clk); #1;
      check($sformatf("rand%0d_level", cyc), DW'(level), DW'(q.size()));
      check($sformatf("rand%0d_range", cyc), DW'(int'(level) <= DP), DW'(1));
      check($sformatf("rand%0d_valid", cyc), DW'(popValid), DW'(mValid));
      if (mValid) begin
        check($sformatf("rand%0d_data", cyc), popData, mData);
        check($sformatf("rand%0d_count", cyc), DW'(popCount), DW'(mCount));
      end
    end

    // Narrow instance: 4-bit units, 8 lanes, depth 20.
    @(negedge clk);
    bRst = 1'b1;
    @(posedge clk); #1;
    check("b_rst_level", DW'(bLevel), DW'(0));
    check("b_rst_valid", DW'(bPopValid), DW'(0));
    @(negedge clk);
    bRst = 1'b0; bJoinEn = 1'b1; bJoinAmt = 3'd7; bJoinData = 32'h87654321;
    #1 check("b_join1_permit", DW'(bJoinPermit), DW'(1));
    @(posedge clk); #1 check("b_join1_level", DW'(bLevel), DW'(8));
    @(negedge clk);
    bJoinData = 32'h0FEDCBA9;
    #1 check("b_join2_permit", DW'(bJoinPermit), DW'(1));
    @(posedge clk); #1 check("b_join2_level", DW'(bLevel), DW'(16));
    @(negedge clk);
    bJoinData = 32'h11111111;
    #1 check("b_join3_permit", DW'(bJoinPermit), DW'(0));
    @(posedge clk); #1 check("b_join3_level", DW'(bLevel), DW'(16));
    @(negedge clk);
    bJoinEn = 1'b0; bPopPermit = 1'b1; bPopAmt = 3'd7;
    #1 check("b_pop_en", DW'(bPopEn), DW'(1));
    @(posedge clk); #1;
    check("b_pop_valid", DW'(bPopValid), DW'(1));
    check("b_pop_data", DW'(bPopData), DW'(32'h87654321));
    check("b_pop_count", DW'(bPopCount), DW'(7));
    check("b_pop_level", DW'(bLevel), DW'(8));
    @(negedge clk);
    bPopPermit = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pfifo_gearbox.md
# pfifo_gearbox

Parametrised byte-granular gearbox FIFO for the rate de-matching datapath. A producer joins 1..LANES units per cycle and a consumer pops 1..LANES units per cycle, with independent amounts, in strict unit order. It extends the fixed 8-bit/32-lane/96-unit parallel FIFO with the following:
- generic unit width, lane count and depth;
- a registered pop output stage;
- a synchronous flush;
- a drain mode that releases a partial tail;
- a live occupancy output.

## Interface
- UNIT_W, 8, bits per unit
- LANES, 32, max units per join/pop; AW = clog2(LANES)
- DEPTH, 96, storage capacity in units; must be >= LANES; CW = clog2(DEPTH+1)
- i_core_clk  in  1  system clock; all logic on rising edge
- i_rx_rst  in  1  reset, synchronous, active-high
- i_flush  in  1  synchronous clear of contents
- i_join_en  in  1  producer write request
- i_join_amount  in  AW  units to write minus one
- i_join_data  in  LANES*UNIT_W  LSB-aligned; unit k = bits [k*UNIT_W +: UNIT_W]; unit 0 oldest
- o_join_permit  out  1  combinational; write accepted when i_join_en & o_join_permit
- i_pop_permit  in  1  consumer ready
- i_pop_amount  in  AW  units requested minus one
- i_pop_drain  in  1  permit a short pop of all remaining units
- o_pop_en  out  1  combinational grant strobe for this cycle's pop
- o_pop_valid  out  1  registered; o_pop_data/o_pop_count valid
- o_pop_data  out  LANES*UNIT_W  registered, LSB-aligned, unit 0 oldest, unused units zero
- o_pop_count  out  AW  registered, units delivered minus one
- o_level  out  CW  registered occupancy in units

## Operation
- n_join = i_join_amount+1, n_pop_req = i_pop_amount+1. All comparisons use CW+1 bits with no wrap.
- o_join_permit = !i_rx_rst & !i_flush & (o_level + n_join <= DEPTH). Uses current level only; a same-cycle pop does not free space.
- Grant conditions (combinational), with i_rx_rst=0, i_flush=0 and i_pop_permit=1:
  - normal: o_pop_en=1 if o_level >= n_pop_req; n_pop = n_pop_req.
  - drain: i_pop_drain=1 and 0 < o_level < n_pop_req gives o_pop_en=1 with n_pop = o_level.
  - otherwise o_pop_en=0.
- A same-cycle join is never visible to the pop decision.
- Level update: level_next = level + (join? n_join:0) − (pop? n_pop:0). Join+pop in the same cycle is legal.
- Ordering:
  - Joined units are appended after all stored units, in unit index order.
  - A pop removes the n_pop oldest units.
  - Data is never reordered, duplicated or lost.
- On grant, the next cycle shows:
  - o_pop_valid=1;
  - o_pop_data holds the popped units at units 0..n_pop−1, with units n_pop..LANES−1 zero;
  - o_pop_count=n_pop−1.
- With no grant, o_pop_valid=0 next cycle. o_pop_data and o_pop_count hold their last values.
- Flush:
  - Level becomes 0 next cycle.
  - Stored contents are discarded.
  - Join and pop are both blocked that cycle.
  - o_pop_valid is 0 next cycle.
  - An o_pop_valid already asserted in the flush cycle still completes; it came from the prior grant.
- Precedence: i_rx_rst > i_flush > join/pop.
- Join data bits above n_join*UNIT_W are ignored.

## Timing
- Reset (i_rx_rst=1 at an edge) sets:
  - o_level=0, o_pop_valid=0, o_pop_data=0, o_pop_count=0;
  - storage contents undefined/cleared.
- While i_rx_rst=1, o_join_permit=0 and o_pop_en=0. Reset asserted mid-transfer drops all stored and in-flight data.
- Join-to-pop latency: a unit joined at edge t may be granted at cycle t+1 at the earliest. Its data appears on o_pop_data at edge t+2.
- Pop grant to data: exactly 1 cycle. Back-to-back grants give o_pop_valid high every cycle.
- o_pop_valid has no backpressure; the consumer must accept whenever it asserted i_pop_permit.
- Full: o_level=DEPTH means o_join_permit=0 for any amount. Empty: o_level=0 means o_pop_en=0 even with drain.
- Boundary: level+n_join=DEPTH is permitted exactly. n_pop_req=o_level is granted in normal mode.
- Throughput: one join and one pop per cycle sustained, LANES units each.

## Test plan
- Reset, then join 5 units 0x01..0x05, then pop amount 2 -> o_pop_en the cycle after the join. Next cycle: o_pop_data=0x030201, o_pop_count=2, o_pop_valid=1. o_level goes 5 then 2.
- Fill with three joins of 32 units -> o_level=96. A further join_amount=0 is refused. A same-cycle join of 32 and pop of 32 at level=64 is accepted, and level stays 64.
- Level=3, pop_amount=7, drain=0 -> no grant. With drain=1 -> grant, o_pop_count=2, upper 29 units zero, level 0.
- Level=40 with i_flush plus a simultaneous join -> join refused, o_level=0 next cycle, and no o_pop_valid from any pop that cycle.
- Random join/pop amounts over 10k cycles, checked against a unit-queue model -> exact stream match, and o_level always within 0..96.
- Re-parametrise UNIT_W=4, LANES=8, DEPTH=20. Join 8, join 8, then join 8 -> third join refused at level 16. Pop 8 returns the first 8 nibbles in order.
